wb_req_arbiter: RTL and testbench
=================================

Name: wb_req_arbiter

Overview:
- Shares the single reorder-buffer write port between the three writeback producers: ALU, MUL and dcache.
- Each producer has its own small FIFO. Arbitration among the FIFO heads is round-robin.
- The winning request drives a registered valid/ready output toward the reorder buffer.
- Per-thread flush discards buffered requests of a squashed thread. Sits between the execute/cache stages and the ROB inside the writeback stage.

Parameters:
- REQ_W, 128, packed width of one writeback_request_t payload
- THR_W, 2, thread-id width (THR_PER_CORE_WIDTH)
- NUM_THR, 4, threads per core (THR_PER_CORE)
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, >=2)

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- alu_req_valid / mul_req_valid / cache_req_valid  in  1 each  producer push
- alu_req_info / mul_req_info / cache_req_info  in  REQ_W each  payload
- alu_thread_id / mul_thread_id / cache_thread_id  in  THR_W each  thread of the pushed request
- alu_stall / mul_stall / cache_stall  out  1 each  FIFO full; producer must not push
- flush_thread  in  NUM_THR  one-hot-or-more thread squash
- rob_req_valid  out  1  output request valid
- rob_req_info  out  REQ_W  output payload
- rob_req_thread_id  out  THR_W  output thread
- rob_req_src  out  2  winner: 0=ALU, 1=MUL, 2=cache
- rob_ready  in  1  ROB accepts the output this cycle
- overflow_err  out  3  sticky per-source push-while-full flag, bit0=ALU, bit1=MUL, bit2=cache

Behaviour:
- Reset (reset=0, async):
  - all FIFOs empty and all kill bits clear
  - rob_req_valid=0, rob_req_info=0, rob_req_thread_id=0, rob_req_src=0
  - stalls=0, overflow_err=0, RR pointer=ALU
- FIFO push:
  - A push is accepted when valid=1 and the FIFO's registered count<FIFO_DEPTH.
  - Push while full: request dropped, FIFO unchanged, overflow_err bit set until reset.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Stall: xx_stall = (count==FIFO_DEPTH), driven from registered state only. The stall is high the cycle after the FIFO becomes full.
- Each entry stores {kill, thread, payload}. The write and read pointers wrap modulo FIFO_DEPTH.
- Output register:
  - It is free when rob_req_valid=0, or when rob_req_valid=1 and rob_ready=1.
  - While rob_req_valid=1 and rob_ready=0, info, thread and src hold stable.
- Arbitration, each cycle the output is free:
  - Eligible sources are those with non-empty FIFOs whose head is not killed.
  - The winner is the first eligible source at or after the RR pointer, in order ALU->MUL->cache->ALU.
  - The winner's head is popped and loaded into the output register; rob_req_valid=1 the next cycle.
  - The RR pointer moves to winner+1 (mod 3).
  - No eligible source: rob_req_valid becomes 0 when the output is free; the pointer is unchanged.
- Latency: push at cycle N into an empty FIFO with the output free and no competition -> rob_req_valid=1 at N+1. Minimum latency is one cycle; there is no bypass.
- Throughput: one request per cycle total.
- Flush, for every thread t with flush_thread[t]=1 in cycle N:
  - All buffered entries with thread==t get kill=1 at the N+1 edge. A push of thread t in cycle N is dropped without setting overflow_err.
  - If the output register holds thread t, rob_req_valid=0 at N+1 regardless of rob_ready. An accept in cycle N itself still counts as a transfer.
  - Killed heads are popped silently, one per source per cycle, in parallel with arbitration. They never reach the output and never move the RR pointer.
  - Entries of thread t pushed after cycle N are unaffected.
- Flush arriving while reset is deasserting: no effect, since the FIFOs are already empty.

Optional Feature:
- Macro: WB_ARB_CACHE_PRIO_EN.
- Defined: the cache source has strict priority whenever its head is eligible, and granting the cache does not move the RR pointer. ALU and MUL round-robin between themselves using the pointer. This keeps the dcache pipeline from backing up.
- Undefined: pure 3-way round-robin as described in Behaviour.

Test Plan:
- Single ALU push at cycle 5 (payload 0xA5, thread 1), rob_ready=1 -> rob_req_valid=1 at cycle 6, info 0xA5, thread 1, src 0; valid=0 at cycle 7.
- ALU, MUL and cache all push every cycle with rob_ready=1 -> grants rotate 0,1,2,0,1,2; each stall rises once its FIFO holds 2; no overflow_err.
- rob_ready held 0 for 4 cycles with request 0x33 held at output -> info, src and thread stable for all 4 cycles; the next head appears the cycle after rob_ready=1.
- MUL pushes 3 times with rob_ready=0 and ignores mul_stall -> third push dropped, overflow_err=3'b010 until reset.
- ALU FIFO holds {thr2, thr0}, output holds thr2, flush_thread=4'b0100 -> output valid=0 next cycle; thr2 entry discarded silently; thr0 entry is the next grant.
- With WB_ARB_CACHE_PRIO_EN defined, all three sources continuously pending -> cache wins every cycle it has an entry; without the macro, cache wins every third grant.
- reset asserted low mid-burst with output valid -> rob_req_valid=0 immediately (async), all FIFOs empty after release, the first grant goes to ALU.

Source files
------------

// File: rtl/wb_req_arbiter.sv
// wb_req_arbiter: per-source writeback FIFOs (ALU, MUL, dcache) round-robin arbitrated onto the ROB write port.
// Define WB_ARB_CACHE_PRIO_EN to give the dcache FIFO strict priority over the ALU/MUL round-robin.
module wb_req_arbiter #(
    parameter int REQ_W      = 128,
    parameter int THR_W      = 2,
    parameter int NUM_THR    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alu_req_valid,
    input  logic               mul_req_valid,
    input  logic               cache_req_valid,
    input  logic [REQ_W-1:0]   alu_req_info,
    input  logic [REQ_W-1:0]   mul_req_info,
    input  logic [REQ_W-1:0]   cache_req_info,
    input  logic [THR_W-1:0]   alu_thread_id,
    input  logic [THR_W-1:0]   mul_thread_id,
    input  logic [THR_W-1:0]   cache_thread_id,
    output logic               alu_stall,
    output logic               mul_stall,
    output logic               cache_stall,
    input  logic [NUM_THR-1:0] flush_thread,
    output logic               rob_req_valid,
    output logic [REQ_W-1:0]   rob_req_info,
    output logic [THR_W-1:0]   rob_req_thread_id,
    output logic [1:0]         rob_req_src,
    input  logic               rob_ready,
    output logic [2:0]         overflow_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [2:0]            in_valid;
    logic [REQ_W-1:0]      in_info [3];
    logic [THR_W-1:0]      in_thr [3];
    logic [REQ_W-1:0]      pay_q [3][FIFO_DEPTH], pay_d [3][FIFO_DEPTH];
    logic [THR_W-1:0]      thr_q [3][FIFO_DEPTH], thr_d [3][FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill_q [3], kill_d [3];
    logic [AW-1:0]         wr_q [3], wr_d [3], rd_q [3], rd_d [3];
    logic [CW-1:0]         cnt_q [3], cnt_d [3];
    logic [2:0]            ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [REQ_W-1:0]      info_q, info_d;
    logic [THR_W-1:0]      othr_q, othr_d;
    logic [1:0]            src_q, src_d, rr_q, rr_d;
    logic [2:0]            full, nonempty, dead, elig, in_flushed, push, pop, gnt;
    logic                  out_free, load;
    logic [1:0]            gnt_src;

    assign in_valid = {cache_req_valid, mul_req_valid, alu_req_valid};
    assign in_info  = '{alu_req_info, mul_req_info, cache_req_info};
    assign in_thr   = '{alu_thread_id, mul_thread_id, cache_thread_id};

    // A head whose thread is flushed this cycle is already treated as killed so it can never be granted.
    always_comb begin
        full       = '0;
        nonempty   = '0;
        dead       = '0;
        in_flushed = '0;
        for (int s = 0; s < 3; s++) begin
            full[s]       = cnt_q[s] == CW'(FIFO_DEPTH);
            nonempty[s]   = cnt_q[s] != '0;
            dead[s]       = kill_q[s][rd_q[s]] | flush_thread[thr_q[s][rd_q[s]]];
            in_flushed[s] = flush_thread[in_thr[s]];
        end
        elig = nonempty & ~dead;
        push = in_valid & ~full & ~in_flushed;
    end

`ifdef WB_ARB_CACHE_PRIO_EN
    always_comb begin
        gnt_src = elig[2] ? 2'd2 : (elig[0] & elig[1]) ? ((rr_q == 2'd1) ? 2'd1 : 2'd0) : {1'b0, elig[1]};
        rr_d    = (load && gnt_src != 2'd2) ? gnt_src + 2'd1 : rr_q;
    end
`else
    logic [1:0] c0, c1, c2;
    always_comb begin
        c0      = rr_q;
        c1      = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        c2      = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;
        gnt_src = elig[c0] ? c0 : elig[c1] ? c1 : c2;
        rr_d    = load ? ((gnt_src == 2'd2) ? 2'd0 : gnt_src + 2'd1) : rr_q;
    end
`endif

    assign out_free = ~valid_q | rob_ready;
    assign load     = out_free & (|elig);
    assign gnt      = load ? (3'b001 << gnt_src) : 3'b000;
    assign pop      = gnt | (nonempty & dead);

    always_comb begin
        pay_d  = pay_q;
        thr_d  = thr_q;
        kill_d = kill_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | (in_valid & full & ~in_flushed);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                kill_d[s][i] = kill_q[s][i] | flush_thread[thr_q[s][i]];
            if (push[s]) begin
                pay_d[s][wr_q[s]]  = in_info[s];
                thr_d[s][wr_q[s]]  = in_thr[s];
                kill_d[s][wr_q[s]] = 1'b0;
                wr_d[s]            = wr_q[s] + AW'(1);
            end
            if (pop[s])
                rd_d[s] = rd_q[s] + AW'(1);
            cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
        // A held output of a flushed thread is dropped even if the ROB is not ready.
        valid_d = load | (valid_q & ~out_free & ~flush_thread[othr_q]);
        info_d  = load ? pay_q[gnt_src][rd_q[gnt_src]] : info_q;
        othr_d  = load ? thr_q[gnt_src][rd_q[gnt_src]] : othr_q;
        src_d   = load ? gnt_src : src_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pay_q   <= '{default: '0};
            thr_q   <= '{default: '0};
            kill_q  <= '{default: '0};
            wr_q    <= '{default: '0};
            rd_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            ovf_q   <= '0;
            valid_q <= 1'b0;
            info_q  <= '0;
            othr_q  <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            pay_q   <= pay_d;
            thr_q   <= thr_d;
            kill_q  <= kill_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            info_q  <= info_d;
            othr_q  <= othr_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign {cache_stall, mul_stall, alu_stall} = full;
    assign rob_req_valid     = valid_q;
    assign rob_req_info      = info_q;
    assign rob_req_thread_id = othr_q;
    assign rob_req_src       = src_q;
    assign overflow_err      = ovf_q;
endmodule

// File: tb/tb_wb_req_arbiter.sv
// tb_wb_req_arbiter: directed tests for wb_req_arbiter (expectations follow WB_ARB_CACHE_PRIO_EN when defined).
module tb_wb_req_arbiter;
    localparam int REQ_W = 128;
    localparam int THR_W = 2;
    localparam int NUM_THR = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               alu_req_valid, mul_req_valid, cache_req_valid;
    logic [REQ_W-1:0]   alu_req_info, mul_req_info, cache_req_info;
    logic [THR_W-1:0]   alu_thread_id, mul_thread_id, cache_thread_id;
    logic               alu_stall, mul_stall, cache_stall;
    logic [NUM_THR-1:0] flush_thread;
    logic               rob_req_valid;
    logic [REQ_W-1:0]   rob_req_info;
    logic [THR_W-1:0]   rob_req_thread_id;
    logic [1:0]         rob_req_src;
    logic               rob_ready;
    logic [2:0]         overflow_err;
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    wb_req_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_req_valid(alu_req_valid), .mul_req_valid(mul_req_valid), .cache_req_valid(cache_req_valid),
        .alu_req_info(alu_req_info), .mul_req_info(mul_req_info), .cache_req_info(cache_req_info),
        .alu_thread_id(alu_thread_id), .mul_thread_id(mul_thread_id), .cache_thread_id(cache_thread_id),
        .alu_stall(alu_stall), .mul_stall(mul_stall), .cache_stall(cache_stall),
        .flush_thread(flush_thread),
        .rob_req_valid(rob_req_valid), .rob_req_info(rob_req_info),
        .rob_req_thread_id(rob_req_thread_id), .rob_req_src(rob_req_src),
        .rob_ready(rob_ready), .overflow_err(overflow_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_req_valid = 0; mul_req_valid = 0; cache_req_valid = 0;
        alu_req_info = '0; mul_req_info = '0; cache_req_info = '0;
        alu_thread_id = '0; mul_thread_id = '0; cache_thread_id = '0;
        flush_thread = '0; rob_ready = 1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #1 reset = 0;
        #1;
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", rob_req_valid); end
        tests++; if (rob_req_info !== '0) begin fails++; $display("FAIL reset_info: got %h exp 0", rob_req_info); end
        tests++; if (rob_req_thread_id !== 2'd0) begin fails++; $display("FAIL reset_thr: got %0d exp 0", rob_req_thread_id); end
        tests++; if (rob_req_src !== 2'd0) begin fails++; $display("FAIL reset_src: got %0d exp 0", rob_req_src); end
        tests++; if ({cache_stall, mul_stall, alu_stall} !== 3'b000) begin fails++; $display("FAIL reset_stall: got %b exp 000", {cache_stall, mul_stall, alu_stall}); end
        tests++; if (overflow_err !== 3'b000) begin fails++; $display("FAIL reset_ovf: got %b exp 000", overflow_err); end
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic test_single();
        apply_reset();
        repeat (3) step();
        alu_req_valid = 1; alu_req_info = REQ_W'('hA5); alu_thread_id = 2'd1;
        step();
        alu_req_valid = 0;
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL single_nobypass: got %b exp 0", rob_req_valid); end
        step();
        tests++; if (rob_req_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", rob_req_valid); end
        tests++; if (rob_req_info !== REQ_W'('hA5)) begin fails++; $display("FAIL single_info: got %h exp a5", rob_req_info); end
        tests++; if (rob_req_thread_id !== 2'd1) begin fails++; $display("FAIL single_thr: got %0d exp 1", rob_req_thread_id); end
        tests++; if (rob_req_src !== 2'd0) begin fails++; $display("FAIL single_src: got %0d exp 0", rob_req_src); end
        step();
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %b exp 0", rob_req_valid); end
    endtask

    task automatic test_rotation();
        int na = 0, nm = 0, nc = 0;
        logic [1:0] exp_src;
        logic [REQ_W-1:0] exp_info;
        logic [2:0] exp_stall;
        apply_reset();
        alu_req_valid = 1; mul_req_valid = 1; cache_req_valid = 1;
        alu_req_info = REQ_W'('h100); mul_req_info = REQ_W'('h200); cache_req_info = REQ_W'('h300);
        step();
        na = 1; nm = 1; nc = 1;
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL rot_first_valid: got %b exp 0", rob_req_valid); end
        tests++; if ({cache_stall, mul_stall, alu_stall} !== 3'b000) begin fails++; $display("FAIL rot_first_stall: got %b exp 000", {cache_stall, mul_stall, alu_stall}); end
        for (int j = 0; j < 6; j++) begin
            alu_req_valid = !alu_stall; mul_req_valid = !mul_stall; cache_req_valid = !cache_stall;
            alu_req_info = REQ_W'('h100 + na); mul_req_info = REQ_W'('h200 + nm); cache_req_info = REQ_W'('h300 + nc);
            step();
            na += int'(alu_req_valid); nm += int'(mul_req_valid); nc += int'(cache_req_valid);
`ifdef WB_ARB_CACHE_PRIO_EN
            exp_src = 2'd2; exp_info = REQ_W'('h300 + j); exp_stall = 3'b011;
`else
            exp_src = 2'(j % 3); exp_info = REQ_W'('h100 * (j % 3 + 1) + j / 3); exp_stall = 3'b110;
`endif
            tests++; if (rob_req_valid !== 1'b1) begin fails++; $display("FAIL rot_valid[%0d]: got %b exp 1", j, rob_req_valid); end
            tests++; if (rob_req_src !== exp_src) begin fails++; $display("FAIL rot_src[%0d]: got %0d exp %0d", j, rob_req_src, exp_src); end
            tests++; if (rob_req_info !== exp_info) begin fails++; $display("FAIL rot_info[%0d]: got %h exp %h", j, rob_req_info, exp_info); end
            if (j == 0) begin
                tests++; if ({cache_stall, mul_stall, alu_stall} !== exp_stall) begin fails++; $display("FAIL rot_stall: got %b exp %b", {cache_stall, mul_stall, alu_stall}, exp_stall); end
            end
        end
        idle_inputs();
        step();
        tests++; if (overflow_err !== 3'b000) begin fails++; $display("FAIL rot_ovf: got %b exp 000", overflow_err); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rob_ready = 0;
        alu_req_valid = 1; alu_req_info = REQ_W'('h33); alu_thread_id = 2'd3;
        step();
        alu_req_info = REQ_W'('h44); alu_thread_id = 2'd0;
        step();
        alu_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (rob_req_valid !== 1'b1 || rob_req_info !== REQ_W'('h33) || rob_req_src !== 2'd0 || rob_req_thread_id !== 2'd3) begin
                fails++; $display("FAIL bp_hold[%0d]: got v=%b info=%h src=%0d thr=%0d exp v=1 info=33 src=0 thr=3", k, rob_req_valid, rob_req_info, rob_req_src, rob_req_thread_id);
            end
            if (k < 3) step();
        end
        rob_ready = 1;
        step();
        tests++; if (rob_req_valid !== 1'b1 || rob_req_info !== REQ_W'('h44) || rob_req_thread_id !== 2'd0) begin
            fails++; $display("FAIL bp_next: got v=%b info=%h thr=%0d exp v=1 info=44 thr=0", rob_req_valid, rob_req_info, rob_req_thread_id);
        end
        step();
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b exp 0", rob_req_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        rob_ready = 0;
        alu_req_valid = 1; alu_req_info = REQ_W'('h11);
        step();
        alu_req_valid = 0;
        step();
        mul_req_valid = 1;
        for (int k = 0; k < 3; k++) begin
            mul_req_info = REQ_W'('h20 + k);
            step();
            if (k == 1) begin
                tests++; if (mul_stall !== 1'b1) begin fails++; $display("FAIL ovf_stall: got %b exp 1", mul_stall); end
                tests++; if (overflow_err !== 3'b000) begin fails++; $display("FAIL ovf_early: got %b exp 000", overflow_err); end
            end
        end
        mul_req_valid = 0;
        tests++; if (overflow_err !== 3'b010) begin fails++; $display("FAIL ovf_set: got %b exp 010", overflow_err); end
        rob_ready = 1;
        step();
        tests++; if (rob_req_info !== REQ_W'('h20) || rob_req_src !== 2'd1) begin fails++; $display("FAIL ovf_d0: got info=%h src=%0d exp info=20 src=1", rob_req_info, rob_req_src); end
        step();
        tests++; if (rob_req_info !== REQ_W'('h21) || rob_req_valid !== 1'b1) begin fails++; $display("FAIL ovf_d1: got info=%h v=%b exp info=21 v=1", rob_req_info, rob_req_valid); end
        step();
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL ovf_dropped: got v=%b exp 0", rob_req_valid); end
        tests++; if (overflow_err !== 3'b010) begin fails++; $display("FAIL ovf_sticky: got %b exp 010", overflow_err); end
        apply_reset();
        tests++; if (overflow_err !== 3'b000) begin fails++; $display("FAIL ovf_clear: got %b exp 000", overflow_err); end
    endtask

    task automatic test_flush();
        apply_reset();
        rob_ready = 0;
        alu_req_valid = 1; alu_req_info = REQ_W'('hA0); alu_thread_id = 2'd2;
        step();
        alu_req_info = REQ_W'('hB0);
        step();
        alu_req_info = REQ_W'('hC0); alu_thread_id = 2'd0;
        step();
        tests++; if (alu_stall !== 1'b1 || rob_req_valid !== 1'b1 || rob_req_thread_id !== 2'd2) begin
            fails++; $display("FAIL flush_setup: got stall=%b v=%b thr=%0d exp stall=1 v=1 thr=2", alu_stall, rob_req_valid, rob_req_thread_id);
        end
        alu_req_valid = 0;
        flush_thread = 4'b0100;
        mul_req_valid = 1; mul_req_info = REQ_W'('hD0); mul_thread_id = 2'd2;
        step();
        flush_thread = '0; mul_req_valid = 0;
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL flush_out: got %b exp 0", rob_req_valid); end
        tests++; if (alu_stall !== 1'b0) begin fails++; $display("FAIL flush_killpop: got stall=%b exp 0", alu_stall); end
        tests++; if (overflow_err !== 3'b000) begin fails++; $display("FAIL flush_ovf: got %b exp 000", overflow_err); end
        rob_ready = 1;
        step();
        tests++; if (rob_req_valid !== 1'b1 || rob_req_info !== REQ_W'('hC0) || rob_req_thread_id !== 2'd0 || rob_req_src !== 2'd0) begin
            fails++; $display("FAIL flush_next: got v=%b info=%h thr=%0d src=%0d exp v=1 info=c0 thr=0 src=0", rob_req_valid, rob_req_info, rob_req_thread_id, rob_req_src);
        end
        step();
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL flush_gone: got %b exp 0", rob_req_valid); end
    endtask

    task automatic test_async_reset();
        logic [1:0] exp_src;
        apply_reset();
        alu_req_valid = 1; mul_req_valid = 1; cache_req_valid = 1;
        alu_req_info = REQ_W'('h7A); mul_req_info = REQ_W'('h7B); cache_req_info = REQ_W'('h7C);
        step();
        step();
        tests++; if (rob_req_valid !== 1'b1) begin fails++; $display("FAIL ares_pre: got %b exp 1", rob_req_valid); end
        #2 reset = 0;
        #1;
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL ares_valid: got %b exp 0", rob_req_valid); end
        tests++; if ({cache_stall, mul_stall, alu_stall} !== 3'b000) begin fails++; $display("FAIL ares_stall: got %b exp 000", {cache_stall, mul_stall, alu_stall}); end
        idle_inputs();
        step();
        reset = 1;
        step();
        tests++; if (rob_req_valid !== 1'b0) begin fails++; $display("FAIL ares_empty: got %b exp 0", rob_req_valid); end
        alu_req_valid = 1; mul_req_valid = 1; cache_req_valid = 1;
        step();
        idle_inputs();
        step();
`ifdef WB_ARB_CACHE_PRIO_EN
        exp_src = 2'd2;
`else
        exp_src = 2'd0;
`endif
        tests++; if (rob_req_valid !== 1'b1 || rob_req_src !== exp_src) begin fails++; $display("FAIL ares_first: got v=%b src=%0d exp v=1 src=%0d", rob_req_valid, rob_req_src, exp_src); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
